// File: rtl/rd_handshake_arb_if.sv
// Read handshake bundle between the requester blocks and rd_handshake_arb.
// master: requester side, drives the per-channel rd levels.
// slave:  arbiter side, drives the strobe, grant/ack, tag and status outputs.
interface rd_handshake_arb_if #(
    parameter int CH = 4,
    parameter int DW = 8
);
    logic [CH-1:0] rd;
    logic          rd_data;
    logic [CH-1:0] grant;
    logic [CH-1:0] ack;
    logic [DW-1:0] data;
    logic          busy;
    logic          err;

    modport master (output rd, input rd_data, grant, ack, data, busy, err);
    modport slave  (input rd, output rd_data, grant, ack, data, busy, err);
endinterface

// File: rtl/rd_handshake_arb.sv
// rd_handshake_arb: round-robin arbiter in front of one slow read resource.
// IDLE -> READ (WAIT cycles, rd_data strobe) -> ACK_NOW (ack held until the
// owner drops rd). Every completed transaction returns an incrementing tag.
// Optional feature macro: RD_TIMEOUT_EN bounds the ACK_NOW stay to TIMEOUT
// cycles, pulses err and blocks the offending channel until it drops rd.
module rd_handshake_arb #(
    parameter int CH      = 4,
    parameter int WAIT    = 1,
    parameter int DW      = 8,
    parameter int TIMEOUT = 8
) (
    input logic               clk,
    input logic               rst,
    rd_handshake_arb_if.slave bus_io
);
    localparam int IW = $clog2(CH);

    if (CH < 2 || CH > 8 || WAIT < 1 || WAIT > 15) begin : g_badParam
        $error("rd_handshake_arb: CH must be 2..8 and WAIT 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        ACK_NOW = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CH-1:0] grant_q, grant_d;
    logic [CH-1:0] ack_q;
    logic [IW-1:0] gIdx_q, gIdx_d;
    logic [IW-1:0] lastGrant_q, lastGrant_d;
    logic [3:0]    waitCnt_q, waitCnt_d;
    logic [DW-1:0] seq_q, seq_d;
    logic [DW-1:0] data_q, data_d;
    logic          rdData_q, busy_q;
    logic [CH-1:0] req;
    logic          ownerRd;

    // First requesting channel searching upward from last+1, wrapping at CH.
    function automatic logic [IW-1:0] rrPick(input logic [CH-1:0] r, input logic [IW-1:0] last);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = last;
        found = 1'b0;
        for (int i = 1; i <= CH; i++) begin
            idx = (int'(last) + i) % CH;
            if (!found && r[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign ownerRd = bus_io.rd[gIdx_q];

`ifdef RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CH-1:0] blocked_q, blocked_d;
    logic          err_q, err_d;

    assign req        = bus_io.rd & ~blocked_q;
    assign bus_io.err = err_q;
`else
    assign req        = bus_io.rd;
    assign bus_io.err = 1'b0;
`endif

    // Next-state, arbitration and tag bookkeeping for the handshake FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gIdx_d      = gIdx_q;
        lastGrant_d = lastGrant_q;
        waitCnt_d   = waitCnt_q;
        seq_d       = seq_q;
        data_d      = data_q;
`ifdef RD_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = 1'b0;
        blocked_d   = blocked_q & bus_io.rd;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gIdx_d          = rrPick(req, lastGrant_q);
                    grant_d         = '0;
                    grant_d[gIdx_d] = 1'b1;
                    waitCnt_d       = '0;
                    state_d         = READ;
                end
            end
            READ: begin
                if (!ownerRd) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (waitCnt_q == 4'(WAIT - 1)) begin
                    seq_d   = seq_q + DW'(1);
                    data_d  = seq_q + DW'(1);
                    state_d = ACK_NOW;
`ifdef RD_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
            ACK_NOW: begin
                if (!ownerRd) begin
                    grant_d     = '0;
                    data_d      = '0;
                    lastGrant_d = gIdx_q;
                    state_d     = IDLE;
`ifdef RD_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    grant_d     = '0;
                    data_d      = '0;
                    lastGrant_d = gIdx_q;
                    err_d       = 1'b1;
                    blocked_d   = (blocked_q & bus_io.rd) | grant_q;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`endif
                end
            end
            default: begin
                grant_d = '0;
                data_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered Moore outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            gIdx_q      <= '0;
            lastGrant_q <= IW'(CH - 1);
            waitCnt_q   <= '0;
            seq_q       <= '0;
            data_q      <= '0;
            rdData_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ack_q       <= (state_d == ACK_NOW) ? grant_d : '0;
            gIdx_q      <= gIdx_d;
            lastGrant_q <= lastGrant_d;
            waitCnt_q   <= waitCnt_d;
            seq_q       <= seq_d;
            data_q      <= data_d;
            rdData_q    <= (state_d == READ);
            busy_q      <= (state_d != IDLE);
        end
    end

`ifdef RD_TIMEOUT_EN
    // ACK_NOW stay counter, err pulse and per-channel re-request block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q     <= '0;
            err_q     <= 1'b0;
            blocked_q <= '0;
        end else begin
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            blocked_q <= blocked_d;
        end
    end
`endif

    assign bus_io.rd_data = rdData_q;
    assign bus_io.grant   = grant_q;
    assign bus_io.ack     = ack_q;
    assign bus_io.data    = data_q;
    assign bus_io.busy    = busy_q;
endmodule

// File: doc/rd_handshake_arb.md
Name: rd_handshake_arb

Overview:
- Parametrised successor to the single-requester IDLE/READ/ACK_NOW read handshake state machine.
- Serves CH requesters through one shared read path, using round-robin arbitration.
- READ phase lasts a programmable number of cycles; a per-transaction sequence tag is returned with ack.
- Sits between requester blocks and a single slow read resource.

Parameters:
- CH, 4: number of requesters (2..8).
- WAIT, 1: cycles spent in READ before ACK_NOW (1..15); WAIT=1 matches the original single-channel timing.
- DW, 8: width of the data/sequence tag.
- TIMEOUT, 8: max cycles in ACK_NOW (used only with RD_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- rd  in  CH  per-channel read request (level; held until ack seen, then dropped).
- rd_data  out  1  high while in READ (shared read strobe).
- grant  out  CH  one-hot owner of the current transaction; 0 in IDLE.
- ack  out  CH  one-hot acknowledge to the owner, high throughout ACK_NOW.
- data  out  DW  sequence tag of the current transaction; valid while any ack bit is high.
- busy  out  1  high in READ or ACK_NOW.
- err  out  1  timeout pulse; tied 0 unless RD_TIMEOUT_EN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-low.
- Moore machine; all outputs are registered. Three states: IDLE, READ, ACK_NOW (2-bit encoding).
- Reset (rst=0 at posedge):
  - state=IDLE; rd_data=0, grant=0, ack=0, data=0, busy=0, err=0.
  - seq counter=0; wait counter=0.
  - last-grant pointer=CH-1, so channel 0 has top priority after reset.
  - Reset mid-transaction aborts immediately; no ack is issued.
- IDLE:
  - If rd≠0, select the first set bit searching upward from last_grant+1 (mod CH).
  - Latch it into grant; go to READ; clear the wait counter.
  - If rd=0, stay in IDLE.
- READ:
  - rd_data=1, busy=1.
  - If rd[g]=0 (owner withdrew): go to IDLE, grant cleared; no ack; pointer not advanced; seq unchanged.
  - Else if wait counter == WAIT-1: go to ACK_NOW; seq increments by 1 (wraps mod 2^DW); data takes the new seq value.
  - Else: wait counter +1.
  - Other channels' rd bits are ignored until the machine returns to IDLE.
- ACK_NOW:
  - ack[g]=1, rd_data=0, busy=1; data held stable.
  - Stay while rd[g]=1.
  - When rd[g]=0: go to IDLE; ack, grant and data cleared; last_grant := g.
- Latency:
  - rd rising to rd_data: 1 cycle.
  - rd_data to ack: WAIT cycles.
  - rd falling to ack falling: 1 cycle.
- Simultaneous requests: exactly one grant per transaction, by rotating priority. A continuously requesting channel waits at most CH-1 transactions.
- Back-to-back: after returning to IDLE, a new request is accepted on the next edge; at least one IDLE cycle is always inserted.
- Unused rd bits above CH do not exist; values CH>8 or WAIT=0 are illegal (elaboration check).

Optional Feature:
- RD_TIMEOUT_EN defined:
  - A cycle counter runs in ACK_NOW.
  - If rd[g] is still high after TIMEOUT cycles in ACK_NOW: force IDLE, pulse err=1 for one cycle, clear ack/grant/data, last_grant := g.
  - The offending channel must drop rd and re-raise it before it is granted again.
- Not defined: ACK_NOW persists indefinitely while rd[g]=1; err is constant 0; no timeout counter is synthesised.

Test Plan:
- Reset then single request, WAIT=1: rst=0 two cycles, rst=1, rd=4'b0001 held.
  - Required: 1 cycle later grant=0001, rd_data=1.
  - Next cycle: ack=0001, data=1, rd_data=0.
  - Drop rd: ack=0 after 1 cycle, busy=0.
- Withdrawal during READ, WAIT=3: rd=0010 raised, dropped after 1 READ cycle.
  - Required: return to IDLE, ack never asserted, data=0, seq unchanged (next ack shows data=1).
- Round-robin: rd=4'b1011 held constantly, each owner drops its bit for 1 cycle after its ack.
  - Required: grant order 0001, 0010, 1000, 0001; data 1, 2, 3, 4.
- Held ACK_NOW and wrap: DW=2, five sequential transactions on ch2, rd held 5 cycles in ACK_NOW each time.
  - Required: ack stays high all 5 cycles; data 1, 2, 3, 0, 1.
- Reset mid-operation: rst=0 while in ACK_NOW with ack=0100.
  - Required: next edge all outputs 0; then with rd=1111, channel 0 is granted first.
- With RD_TIMEOUT_EN and TIMEOUT=8: rd=0001 held indefinitely.
  - Required: after 8 ACK_NOW cycles, err=1 for exactly one cycle and ack=0.
  - No regrant until rd[0] toggles low then high.
